countdown_timer: RTL and testbench

Countdown counterpart of the stopwatch: the user presets a time in mm:ss.cc, starts it, and the block counts down in 10 ms steps. It raises ALARM for a fixed duration when the time reaches zero. It sits between the debounced button block (single-cycle pulse inputs) and the 7-segment decoders, which are driven from its six BCD digit outputs.

---
 rtl/countdown_timer_pkg.sv | 20 ++
 rtl/cnt_bcd2_updown.sv | 72 +++++++
 rtl/countdown_timer.sv | 177 +++++++++++++++++
 tb/tb_countdown_timer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the mm:ss.cc countdown timer.
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ALARM = 2'd3
   } state_t;

   localparam int unsigned DIGIT_W  = 4;
   localparam int unsigned MOD_SEC  = 60;
   localparam int unsigned MOD_CENT = 100;

   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/cnt_bcd2_updown.sv
// Two-digit BCD counter: wrapping edit increment, borrow-chained decrement.
module cnt_bcd2_updown
   import countdown_timer_pkg::*;
#(
   parameter int unsigned MOD = MOD_CENT
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               CLR,
   input  logic               INC,
   input  logic               DEC,
   output logic [DIGIT_W-1:0] QH,
   output logic [DIGIT_W-1:0] QL,
   output logic               BO,
   output logic               NZ
);

   localparam logic [DIGIT_W-1:0] H_MAX = DIGIT_W'((MOD - 1) / 10);
   localparam logic [DIGIT_W-1:0] L_MAX = DIGIT_W'((MOD - 1) % 10);
   localparam logic [DIGIT_W-1:0] NINE  = DIGIT_W'(9);

   logic [DIGIT_W-1:0] r_qh, r_ql;
   logic [DIGIT_W-1:0] w_qh_n, w_ql_n;
   logic               w_at_zero, w_at_max;

   always_comb begin
      w_qh_n    = r_qh;
      w_ql_n    = r_ql;
      w_at_zero = (r_qh == '0) && (r_ql == '0);
      w_at_max  = (r_qh == H_MAX) && (r_ql == L_MAX);
      BO        = DEC && w_at_zero;
      if (CLR) begin
         w_qh_n = '0;
         w_ql_n = '0;
      end else if (DEC) begin
         if (w_at_zero) begin
            w_qh_n = H_MAX;
            w_ql_n = L_MAX;
         end else if (r_ql == '0) begin
            w_qh_n = r_qh - DIGIT_W'(1);
            w_ql_n = NINE;
         end else begin
            w_ql_n = r_ql - DIGIT_W'(1);
         end
      end else if (INC) begin
         if (w_at_max) begin
            w_qh_n = '0;
            w_ql_n = '0;
         end else if (r_ql == NINE) begin
            w_qh_n = r_qh + DIGIT_W'(1);
            w_ql_n = '0;
         end else begin
            w_ql_n = r_ql + DIGIT_W'(1);
         end
      end
      NZ = (w_qh_n == '0) && (w_ql_n == '0);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_qh <= '0;
         r_ql <= '0;
      end else begin
         r_qh <= w_qh_n;
         r_ql <= w_ql_n;
      end
   end

   assign QH = r_qh;
   assign QL = r_ql;

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer mm:ss.cc with 10 ms steps, pause/resume and timed alarm.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50000000,
   parameter int unsigned TICK_HZ     = 100,
   parameter int unsigned ALARM_TICKS = 300
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       CLR,
   input  logic       SECUP,
   input  logic       MINUP,
   output logic [3:0] QM10,
   output logic [3:0] QM1,
   output logic [3:0] QS10,
   output logic [3:0] QS1,
   output logic [3:0] QC10,
   output logic [3:0] QC1,
   output logic       RUNNING,
   output logic       ALARM,
   output logic       ZERO
);

   localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam int unsigned PW  = $clog2(DIV);
   localparam int unsigned AW  = $clog2(ALARM_TICKS + 1);

   state_t        r_state, w_nxt_base, w_nxt;
   logic [PW-1:0] r_presc;
   logic [AW-1:0] r_alarm_cnt;
   logic          r_running, r_alarm, r_zero;

   logic w_active, w_tick, w_alarm_done;
   logic w_cnt_clr, w_sec_inc, w_min_inc, w_cent_dec;
   logic w_cent_bo, w_sec_bo, w_min_bo;
   logic w_cent_nz, w_sec_nz, w_min_nz, w_next_zero;

   assign w_active     = (r_state == ST_RUN) || (r_state == ST_ALARM);
   assign w_tick       = w_active && (r_presc == PW'(DIV - 1));
   assign w_alarm_done = w_tick && (r_alarm_cnt == AW'(ALARM_TICKS - 1));
   assign w_next_zero  = w_cent_nz && w_sec_nz && w_min_nz;

   // Pulse decoding; the RUN->ALARM decision is taken separately below because
   // it depends on the counters' next value, which in turn depends on w_cent_dec.
   always_comb begin
      w_nxt_base = r_state;
      w_cnt_clr  = 1'b0;
      w_sec_inc  = 1'b0;
      w_min_inc  = 1'b0;
      w_cent_dec = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (CLR) begin
               w_cnt_clr = 1'b1;
            end else if (START) begin
               if (!r_zero) w_nxt_base = ST_RUN;
            end else begin
               w_sec_inc = SECUP;
               w_min_inc = MINUP;
            end
         end
         ST_RUN: begin
            if (CLR) begin
               w_cnt_clr  = 1'b1;
               w_nxt_base = ST_IDLE;
            end else if (START) begin
               w_nxt_base = ST_PAUSE;
            end else if (w_tick) begin
               w_cent_dec = 1'b1;
            end
         end
         ST_PAUSE: begin
            if (CLR) begin
               w_cnt_clr  = 1'b1;
               w_nxt_base = ST_IDLE;
            end else if (START) begin
               w_nxt_base = ST_RUN;
            end
         end
         ST_ALARM: begin
            if (CLR) begin
               w_cnt_clr  = 1'b1;
               w_nxt_base = ST_IDLE;
            end else if (START || w_alarm_done) begin
               w_nxt_base = ST_IDLE;
            end
         end
         default: w_nxt_base = ST_IDLE;
      endcase
   end

   always_comb begin
      w_nxt = w_nxt_base;
      if (w_cent_dec) begin
         if (w_next_zero)
            w_nxt = ST_ALARM;
         else if (w_min_bo)
            w_nxt = ST_IDLE;   // underflow guard; RUN is only entered with a non-zero value
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= ST_IDLE;
         r_running <= 1'b0;
         r_alarm   <= 1'b0;
         r_zero    <= 1'b1;
      end else begin
         r_state   <= w_nxt;
         r_running <= (w_nxt == ST_RUN);
         r_alarm   <= (w_nxt == ST_ALARM);
         r_zero    <= w_next_zero;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         r_presc <= '0;
      else if (w_active && ((w_nxt == ST_RUN) || (w_nxt == ST_ALARM)))
         r_presc <= w_tick ? '0 : r_presc + PW'(1);
      else
         r_presc <= '0;
   end

   // Held at zero outside ALARM, so it is already cleared on entry.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         r_alarm_cnt <= '0;
      else if (r_state != ST_ALARM)
         r_alarm_cnt <= '0;
      else if (w_tick)
         r_alarm_cnt <= r_alarm_cnt + AW'(1);
   end

   cnt_bcd2_updown #(.MOD(MOD_CENT)) u_cent (
      .CLK (CLK),
      .RST (RST),
      .CLR (w_cnt_clr),
      .INC (1'b0),
      .DEC (w_cent_dec),
      .QH  (QC10),
      .QL  (QC1),
      .BO  (w_cent_bo),
      .NZ  (w_cent_nz)
   );

   cnt_bcd2_updown #(.MOD(MOD_SEC)) u_sec (
      .CLK (CLK),
      .RST (RST),
      .CLR (w_cnt_clr),
      .INC (w_sec_inc),
      .DEC (w_cent_bo),
      .QH  (QS10),
      .QL  (QS1),
      .BO  (w_sec_bo),
      .NZ  (w_sec_nz)
   );

   cnt_bcd2_updown #(.MOD(MOD_CENT)) u_min (
      .CLK (CLK),
      .RST (RST),
      .CLR (w_cnt_clr),
      .INC (w_min_inc),
      .DEC (w_sec_bo),
      .QH  (QM10),
      .QL  (QM1),
      .BO  (w_min_bo),
      .NZ  (w_min_nz)
   );

   assign RUNNING = r_running;
   assign ALARM   = r_alarm;
   assign ZERO    = r_zero;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised and directed bench for countdown_timer against a centisecond-total model.
module tb_countdown_timer;

   localparam int unsigned CLK_HZ      = 1000;
   localparam int unsigned TICK_HZ     = 100;
   localparam int unsigned ALARM_TICKS = 5;
   localparam int          DIV         = 10;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_ALARM = 3;

   logic       CLK, RST, START, CLR, SECUP, MINUP;
   logic [3:0] QM10, QM1, QS10, QS1, QC10, QC1;
   logic       RUNNING, ALARM, ZERO;
   logic [23:0] disp;

   int n_checks = 0;
   int n_errors = 0;

   int m_mode, m_total, m_pre, m_acnt;

   countdown_timer #(
      .CLK_HZ      (CLK_HZ),
      .TICK_HZ     (TICK_HZ),
      .ALARM_TICKS (ALARM_TICKS)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .START   (START),
      .CLR     (CLR),
      .SECUP   (SECUP),
      .MINUP   (MINUP),
      .QM10    (QM10),
      .QM1     (QM1),
      .QS10    (QS10),
      .QS1     (QS1),
      .QC10    (QC10),
      .QC1     (QC1),
      .RUNNING (RUNNING),
      .ALARM   (ALARM),
      .ZERO    (ZERO)
   );

   assign disp = {QM10, QM1, QS10, QS1, QC10, QC1};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   always @(negedge CLK) begin
      n_checks++;
      if (QM10 > 9 || QM1 > 9 || QS10 > 5 || QS1 > 9 || QC10 > 9 || QC1 > 9 ||
          (RUNNING && ALARM)) begin
         $display("FAIL invariant disp=%h running=%b alarm=%b", disp, RUNNING, ALARM);
         n_errors++;
      end
   end

   function automatic void model_reset();
      m_mode  = M_IDLE;
      m_total = 0;
      m_pre   = 0;
      m_acnt  = 0;
   endfunction

   function automatic logic [23:0] model_disp();
      int mn, sc, cs;
      mn = m_total / 6000;
      sc = (m_total / 100) % 60;
      cs = m_total % 100;
      return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cs / 10), 4'(cs % 10)};
   endfunction

   function automatic void model_step(input bit s, input bit c, input bit su, input bit mu);
      int  nmode, mn, sc, cs;
      bit  tick, act_now, act_next;
      act_now = (m_mode == M_RUN) || (m_mode == M_ALARM);
      tick    = act_now && (m_pre == DIV - 1);
      nmode   = m_mode;
      case (m_mode)
         M_IDLE: begin
            if (c) m_total = 0;
            else if (s) begin
               if (m_total != 0) nmode = M_RUN;
            end else begin
               mn = m_total / 6000;
               sc = (m_total / 100) % 60;
               cs = m_total % 100;
               if (su) sc = (sc + 1) % 60;
               if (mu) mn = (mn + 1) % 100;
               m_total = mn * 6000 + sc * 100 + cs;
            end
         end
         M_RUN: begin
            if (c) begin
               nmode = M_IDLE;
               m_total = 0;
            end else if (s) nmode = M_PAUSE;
            else if (tick) begin
               m_total = m_total - 1;
               if (m_total == 0) begin
                  nmode  = M_ALARM;
                  m_acnt = 0;
               end
            end
         end
         M_PAUSE: begin
            if (c) begin
               nmode = M_IDLE;
               m_total = 0;
            end else if (s) nmode = M_RUN;
         end
         default: begin
            if (s || c) nmode = M_IDLE;
            else if (tick) begin
               m_acnt++;
               if (m_acnt == ALARM_TICKS) nmode = M_IDLE;
            end
         end
      endcase
      act_next = (nmode == M_RUN) || (nmode == M_ALARM);
      if (act_now && act_next) m_pre = tick ? 0 : m_pre + 1;
      else m_pre = 0;
      m_mode = nmode;
   endfunction

   task automatic do_cycle(input bit s, input bit c, input bit su, input bit mu);
      @(negedge CLK);
      START = s; CLR = c; SECUP = su; MINUP = mu;
      @(posedge CLK);
      model_step(s, c, su, mu);
      #1;
      START = 1'b0; CLR = 1'b0; SECUP = 1'b0; MINUP = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; START = 1'b0; CLR = 1'b0; SECUP = 1'b0; MINUP = 1'b0;
      model_reset();
      #12;
      n_checks++;
      if ({disp, RUNNING, ALARM, ZERO} !== {24'h000000, 3'b001}) begin
         $display("FAIL reset_state got=%h %b%b%b exp=000000 001", disp, RUNNING, ALARM, ZERO);
         n_errors++;
      end
      @(negedge CLK);
      RST = 1'b0;
      do_cycle(1, 0, 0, 0);
      n_checks++;
      if ({disp, RUNNING, ZERO} !== {24'h000000, 2'b01}) begin
         $display("FAIL start_on_zero got=%h run=%b zero=%b exp=000000 run=0 zero=1", disp, RUNNING, ZERO);
         n_errors++;
      end
   endtask

   task automatic test_countdown();
      do_cycle(0, 0, 1, 0);
      do_cycle(0, 0, 1, 0);
      n_checks++;
      if (disp !== 24'h000200) begin
         $display("FAIL secup_x2 got=%h exp=000200", disp); n_errors++;
      end
      do_cycle(1, 0, 0, 0);
      n_checks++;
      if (RUNNING !== 1'b1) begin
         $display("FAIL start_running got=%b exp=1", RUNNING); n_errors++;
      end
      repeat (9) do_cycle(0, 0, 0, 0);
      n_checks++;
      if (disp !== 24'h000200) begin
         $display("FAIL before_first_tick got=%h exp=000200", disp); n_errors++;
      end
      do_cycle(0, 0, 0, 0);
      n_checks++;
      if (disp !== 24'h000199) begin
         $display("FAIL first_tick_edge10 got=%h exp=000199", disp); n_errors++;
      end
      repeat (1989) do_cycle(0, 0, 0, 0);
      n_checks++;
      if ({disp, ALARM} !== {24'h000001, 1'b0}) begin
         $display("FAIL edge1999 got=%h alarm=%b exp=000001 alarm=0", disp, ALARM); n_errors++;
      end
      do_cycle(0, 0, 0, 0);
      n_checks++;
      if ({disp, RUNNING, ALARM, ZERO} !== {24'h000000, 3'b011}) begin
         $display("FAIL reach_zero_alarm got=%h %b%b%b exp=000000 011", disp, RUNNING, ALARM, ZERO);
         n_errors++;
      end
      repeat (49) do_cycle(0, 0, 0, 0);
      n_checks++;
      if (ALARM !== 1'b1) begin
         $display("FAIL alarm_held got=%b exp=1", ALARM); n_errors++;
      end
      do_cycle(0, 0, 0, 0);
      n_checks++;
      if ({disp, RUNNING, ALARM, ZERO} !== {24'h000000, 3'b001}) begin
         $display("FAIL alarm_expire got=%h %b%b%b exp=000000 001", disp, RUNNING, ALARM, ZERO);
         n_errors++;
      end
      n_checks++;
      if (disp !== model_disp() || m_mode != M_IDLE) begin
         $display("FAIL countdown_model got=%h model=%h mode=%0d", disp, model_disp(), m_mode);
         n_errors++;
      end
   endtask

   task automatic test_minutes();
      do_cycle(0, 0, 0, 1);
      n_checks++;
      if (disp !== 24'h010000) begin
         $display("FAIL minup_1 got=%h exp=010000", disp); n_errors++;
      end
      do_cycle(1, 0, 0, 0);
      repeat (10) do_cycle(0, 0, 0, 0);
      n_checks++;
      if (disp !== 24'h005999) begin
         $display("FAIL minute_borrow got=%h exp=005999", disp); n_errors++;
      end
      do_cycle(0, 1, 0, 0);
      n_checks++;
      if ({disp, RUNNING} !== {24'h000000, 1'b0}) begin
         $display("FAIL clr_in_run got=%h run=%b exp=000000 run=0", disp, RUNNING); n_errors++;
      end
      repeat (99) do_cycle(0, 0, 0, 1);
      n_checks++;
      if (disp !== 24'h990000) begin
         $display("FAIL minup_99 got=%h exp=990000", disp); n_errors++;
      end
      do_cycle(0, 0, 0, 1);
      n_checks++;
      if (disp !== 24'h000000) begin
         $display("FAIL minute_wrap got=%h exp=000000", disp); n_errors++;
      end
      do_cycle(0, 0, 0, 1);
      repeat (59) do_cycle(0, 0, 1, 0);
      n_checks++;
      if (disp !== 24'h015900) begin
         $display("FAIL secup_59 got=%h exp=015900", disp); n_errors++;
      end
      do_cycle(0, 0, 1, 0);
      n_checks++;
      if (disp !== 24'h010000) begin
         $display("FAIL second_wrap_no_carry got=%h exp=010000", disp); n_errors++;
      end
      do_cycle(0, 0, 1, 1);
      n_checks++;
      if (disp !== 24'h020100) begin
         $display("FAIL secup_minup_same got=%h exp=020100", disp); n_errors++;
      end
      do_cycle(0, 1, 0, 0);
   endtask

   task automatic test_pause();
      do_cycle(0, 0, 1, 0);
      do_cycle(0, 0, 1, 0);
      do_cycle(1, 0, 0, 0);
      repeat (50) do_cycle(0, 0, 0, 0);
      n_checks++;
      if (disp !== 24'h000195) begin
         $display("FAIL five_ticks got=%h exp=000195", disp); n_errors++;
      end
      do_cycle(1, 0, 0, 0);
      repeat (100) do_cycle(0, 0, 0, 0);
      n_checks++;
      if ({disp, RUNNING, ALARM} !== {24'h000195, 2'b00}) begin
         $display("FAIL pause_hold got=%h %b%b exp=000195 00", disp, RUNNING, ALARM); n_errors++;
      end
      do_cycle(0, 0, 1, 0);
      n_checks++;
      if (disp !== 24'h000195) begin
         $display("FAIL secup_in_pause got=%h exp=000195", disp); n_errors++;
      end
      do_cycle(1, 0, 0, 0);
      n_checks++;
      if (RUNNING !== 1'b1) begin
         $display("FAIL resume_running got=%b exp=1", RUNNING); n_errors++;
      end
      repeat (9) do_cycle(0, 0, 0, 0);
      n_checks++;
      if (disp !== 24'h000195) begin
         $display("FAIL resume_before_tick got=%h exp=000195", disp); n_errors++;
      end
      do_cycle(0, 0, 0, 0);
      n_checks++;
      if (disp !== 24'h000194) begin
         $display("FAIL resume_tick got=%h exp=000194", disp); n_errors++;
      end
      do_cycle(1, 0, 0, 0);
      do_cycle(0, 1, 0, 0);
      n_checks++;
      if ({disp, RUNNING, ZERO} !== {24'h000000, 2'b01}) begin
         $display("FAIL clr_in_pause got=%h run=%b zero=%b exp=000000 0 1", disp, RUNNING, ZERO);
         n_errors++;
      end
   endtask

   task automatic test_priority();
      do_cycle(0, 0, 1, 0);
      do_cycle(1, 0, 0, 0);
      repeat (4) do_cycle(0, 0, 0, 0);
      do_cycle(1, 1, 0, 0);
      n_checks++;
      if ({disp, RUNNING} !== {24'h000000, 1'b0}) begin
         $display("FAIL clr_beats_start got=%h run=%b exp=000000 run=0", disp, RUNNING); n_errors++;
      end
      do_cycle(0, 0, 1, 0);
      do_cycle(1, 0, 1, 0);
      n_checks++;
      if ({disp, RUNNING} !== {24'h000100, 1'b1}) begin
         $display("FAIL start_drops_secup got=%h run=%b exp=000100 run=1", disp, RUNNING); n_errors++;
      end
      repeat (9) do_cycle(0, 0, 0, 0);
      do_cycle(1, 0, 0, 0);
      n_checks++;
      if ({disp, RUNNING} !== {24'h000100, 1'b0}) begin
         $display("FAIL start_beats_tick got=%h run=%b exp=000100 run=0", disp, RUNNING); n_errors++;
      end
      do_cycle(1, 0, 0, 0);
      repeat (1000) do_cycle(0, 0, 0, 0);
      n_checks++;
      if ({disp, ALARM} !== {24'h000000, 1'b1}) begin
         $display("FAIL alarm_after_1s got=%h alarm=%b exp=000000 alarm=1", disp, ALARM); n_errors++;
      end
      do_cycle(1, 0, 0, 0);
      n_checks++;
      if ({RUNNING, ALARM, ZERO} !== 3'b001) begin
         $display("FAIL silence got=%b%b%b exp=001", RUNNING, ALARM, ZERO); n_errors++;
      end
   endtask

   task automatic test_async_reset();
      repeat (3) do_cycle(0, 0, 1, 0);
      do_cycle(1, 0, 0, 0);
      repeat (25) do_cycle(0, 0, 0, 0);
      n_checks++;
      if ({disp, RUNNING} !== {24'h000298, 1'b1}) begin
         $display("FAIL pre_reset_run got=%h run=%b exp=000298 run=1", disp, RUNNING); n_errors++;
      end
      @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      n_checks++;
      if ({disp, RUNNING, ALARM, ZERO} !== {24'h000000, 3'b001}) begin
         $display("FAIL async_reset got=%h %b%b%b exp=000000 001", disp, RUNNING, ALARM, ZERO);
         n_errors++;
      end
      model_reset();
      @(negedge CLK);
      RST = 1'b0;
      do_cycle(1, 0, 0, 0);
      n_checks++;
      if (RUNNING !== 1'b0) begin
         $display("FAIL start_after_reset got=%b exp=0", RUNNING); n_errors++;
      end
   endtask

   task automatic test_random();
      bit s, c, su, mu;
      repeat (4000) begin
         s  = ($urandom_range(0, 149) == 0);
         c  = ($urandom_range(0, 699) == 0);
         su = ($urandom_range(0, 19) == 0);
         mu = ($urandom_range(0, 399) == 0);
         do_cycle(s, c, su, mu);
         n_checks++;
         if ({disp, RUNNING, ALARM, ZERO} !==
             {model_disp(), m_mode == M_RUN, m_mode == M_ALARM, m_total == 0}) begin
            $display("FAIL random got=%h %b%b%b exp=%h %b%b%b", disp, RUNNING, ALARM, ZERO,
                     model_disp(), m_mode == M_RUN, m_mode == M_ALARM, m_total == 0);
            n_errors++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_minutes();
      test_pause();
      test_priority();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
